// File: rtl/vliw_pkg.sv
// Shared VLIW definitions: data/address widths, slot numbering and the
// pending write-back entry type used by the merger and the scoreboard.
package vliw_pkg;

  localparam int XLEN      = 32;
  localparam int RAW       = 5;
  localparam int NUM_SLOTS = 4;

  localparam int SLOT_LSU    = 0;
  localparam int SLOT_IXU1   = 1;
  localparam int SLOT_IXU2   = 2;
  localparam int SLOT_BRANCH = 3;

  typedef struct packed {
    logic            valid;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // True when a lane carries a real write (r0 is hard-wired to zero).
  function automatic logic lane_writes(input logic en, input logic [RAW-1:0] rd);
    return en && (rd != {RAW{1'b0}});
  endfunction

endpackage

// File: rtl/wb_grant.sv
// Combinational write-port arbiter: a pending slot is granted unless a lower
// slot holds a write to the same destination register.
module wb_grant
  import vliw_pkg::*;
(
  input  wb_entry_t [NUM_SLOTS-1:0] i_pend,
  output logic      [NUM_SLOTS-1:0] o_grant,
  output logic                      o_hold
);

  // Per-slot grant: blocked by any valid lower slot with a matching rd.
  always_comb begin
    o_grant = {NUM_SLOTS{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      logic blk;
      blk = 1'b0;
      for (int j = 0; j < i; j++) begin
        blk = blk | (i_pend[j].valid && (i_pend[j].rd == i_pend[i].rd));
      end
      o_grant[i] = i_pend[i].valid & ~blk;
    end
  end

  // Hold when some pending write must wait another cycle.
  always_comb begin
    o_hold = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      o_hold = o_hold | (i_pend[i].valid & ~o_grant[i]);
    end
  end

endmodule

// File: rtl/writeback_merger.sv
// Bundle write-back merger: drops r0 writes and serializes same-rd writes so
// the highest slot's result is the last one committed to the register file.
module writeback_merger
  import vliw_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SLOTS-1:0]      in_lane_en,
  input  logic [NUM_SLOTS*RAW-1:0]  in_lane_rd,
  input  logic [NUM_SLOTS*XLEN-1:0] in_lane_data,
  output logic                      lsu_wr_en,
  output logic                      ixu1_wr_en,
  output logic                      ixu2_wr_en,
  output logic                      branch_wr_en,
  output logic [RAW-1:0]            lsu_rd,
  output logic [RAW-1:0]            ixu1_rd,
  output logic [RAW-1:0]            ixu2_rd,
  output logic [RAW-1:0]            branch_rd,
  output logic [XLEN-1:0]           lsu_wr_data,
  output logic [XLEN-1:0]           ixu1_wr_data,
  output logic [XLEN-1:0]           ixu2_wr_data,
  output logic [XLEN-1:0]           branch_wr_data,
  output logic                      busy,
  output logic [15:0]               collision_cnt
);

  wb_entry_t [NUM_SLOTS-1:0] r_pend;
  logic      [15:0]          r_coll_cnt;
  logic      [NUM_SLOTS-1:0] w_grant;
  logic                      w_hold;
  logic                      w_accept;
  logic      [RAW-1:0]       w_rd   [NUM_SLOTS];
  logic      [XLEN-1:0]      w_data [NUM_SLOTS];

  wb_grant u_grant (
    .i_pend  (r_pend),
    .o_grant (w_grant),
    .o_hold  (w_hold)
  );

  // in_ready is a function of registered state only, never of in_valid.
  assign in_ready = ~w_hold;
  assign w_accept = in_valid & ~w_hold;

  // Pending entries: capture a whole bundle once everything older retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_accept) begin
          r_pend[i].valid <= lane_writes(in_lane_en[i], in_lane_rd[i*RAW +: RAW]);
          r_pend[i].rd    <= in_lane_rd[i*RAW +: RAW];
          r_pend[i].data  <= in_lane_data[i*XLEN +: XLEN];
        end else if (w_grant[i]) begin
          r_pend[i].valid <= 1'b0;
        end else begin
          r_pend[i] <= r_pend[i];
        end
      end
    end
  end

  // Saturating count of cycles in which at least one write was held back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll_cnt <= 16'd0;
    end else if (w_hold && (r_coll_cnt != 16'hFFFF)) begin
      r_coll_cnt <= r_coll_cnt + 16'd1;
    end else begin
      r_coll_cnt <= r_coll_cnt;
    end
  end

  // Write-port address/data are zero whenever the port is idle.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_grant[i]) begin
        w_rd[i]   = r_pend[i].rd;
        w_data[i] = r_pend[i].data;
      end else begin
        w_rd[i]   = {RAW{1'b0}};
        w_data[i] = {XLEN{1'b0}};
      end
    end
  end

  assign lsu_wr_en      = w_grant[SLOT_LSU];
  assign ixu1_wr_en     = w_grant[SLOT_IXU1];
  assign ixu2_wr_en     = w_grant[SLOT_IXU2];
  assign branch_wr_en   = w_grant[SLOT_BRANCH];
  assign lsu_rd         = w_rd[SLOT_LSU];
  assign ixu1_rd        = w_rd[SLOT_IXU1];
  assign ixu2_rd        = w_rd[SLOT_IXU2];
  assign branch_rd      = w_rd[SLOT_BRANCH];
  assign lsu_wr_data    = w_data[SLOT_LSU];
  assign ixu1_wr_data   = w_data[SLOT_IXU1];
  assign ixu2_wr_data   = w_data[SLOT_IXU2];
  assign branch_wr_data = w_data[SLOT_BRANCH];

  // Any valid entry means the merger still owns a write.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      busy = busy | r_pend[i].valid;
    end
  end

  assign collision_cnt = r_coll_cnt;

endmodule

// File: doc/writeback_merger.md
# writeback_merger

Collects one VLIW bundle of results from the four execution slots (LSU, IXU1, IXU2, BRANCH) and drives the four write ports of the shared 32×32-bit register file. It removes writes to r0 and serializes writes that target the same destination within a bundle, so that the highest-numbered slot always leaves the final value. It sits between the execute stage and the register file and applies back-pressure to the bundle issue logic.

## Interface
- `XLEN`, 32, data width of each result.
- `RAW`, 5, register address width; 32 registers.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  a result bundle is presented.
- `in_ready`  out  1  bundle is accepted on the edge where `in_valid && in_ready`.
- `in_lane_en`  in  4  per-slot write request; bit 0 = LSU, 1 = IXU1, 2 = IXU2, 3 = BRANCH.
- `in_lane_rd`  in  4×RAW  per-slot destination register.
- `in_lane_data`  in  4×XLEN  per-slot result.
- `lsu_wr_en`, `ixu1_wr_en`, `ixu2_wr_en`, `branch_wr_en`  out  1 each  register-file write enables.
- `lsu_rd` … `branch_rd`  out  RAW each  write addresses.
- `lsu_wr_data` … `branch_wr_data`  out  XLEN each  write data.
- `busy`  out  1  at least one pending write is held.
- `collision_cnt`  out  16  saturating count of cycles in which a pending write was held back.

## Operation
- State: four pending entries, each holding valid, rd and data; plus `collision_cnt`.
- Capture: on acceptance, slot i becomes pending iff `in_lane_en[i]` is set and `in_lane_rd[i] != 0`. An r0 write is dropped silently.
- Grant rule (combinational from pending state): pending slot i is granted iff no pending slot j < i has the same rd. Among equal-rd writes, lower slots therefore write first, and the highest slot's value persists.
- A granted slot drives its own write port: `*_wr_en` = 1 with the pending rd and data, and its entry clears at the edge.
- A non-granted slot drives `*_wr_en` = 0 and rd/data = 0.
- `in_ready` = (pending & ~grant) == 0. A new bundle is taken on the same edge that the last pending writes retire, so conflict-free bundles stream one per cycle.
- At most one bundle is in flight. A held entry is always older than any bundle not yet accepted, so program order is preserved.
- `busy` = any pending valid.
- `collision_cnt` increments on every cycle with (pending & ~grant) != 0, and saturates at 0xFFFF.

## Timing
- Reset (asserted at any time, including mid-drain): all pending entries cleared, all `*_wr_en` = 0, all rd/data = 0, `busy` = 0, `collision_cnt` = 0, `in_ready` = 1. No capture occurs while `rst_n` is low.
- Latency: a bundle accepted at edge N has every conflict-free write asserted in the cycle after edge N, and committed to the register file at edge N+1.
- k-way collision on one rd: the writes occupy k consecutive cycles, lowest slot first. `in_ready` is low for the first k−1 of those cycles.
- Two independent collision groups drain in parallel; drain length = largest group size.
- `in_valid` with `in_lane_en` = 0, or with only r0 targets: accepted, nothing becomes pending, no write is issued.
- `in_ready` depends only on registered state, with no combinational path from `in_valid`.

## Structure
- Shared package `vliw_pkg`:
  - `XLEN`, `RAW`, `NUM_SLOTS` = 4.
  - slot index constants `SLOT_LSU` = 0, `SLOT_IXU1` = 1, `SLOT_IXU2` = 2, `SLOT_BRANCH` = 3.
  - typedef `wb_entry_t` {valid, rd, data}.
- One sub-module, `wb_grant`: purely combinational. Inputs are the four pending entries; outputs are the 4-bit grant vector and a hold flag. It is reused by the future scoreboard.

## Test plan
- **Reset:** drive `rst_n` low mid-drain with 3 pending writes → next cycle all `*_wr_en` = 0, `busy` = 0, `collision_cnt` = 0, `in_ready` = 1.
- **No conflict:** bundle with rd = {1, 2, 3, 4} and data = {A, B, C, D}, then a second bundle the next cycle → all four ports write in cycle N+1, the second bundle is accepted back-to-back, `collision_cnt` stays 0.
- **r0 drop:** LSU rd = 0 and IXU1 rd = 5 → only `ixu1_wr_en` pulses (rd 5); `lsu_wr_en` never asserts.
- **Three-way collision:** LSU, IXU2 and BRANCH all target rd 7 with data 0x11, 0x22, 0x33 → writes on three consecutive cycles in the order LSU, IXU2, BRANCH. `in_ready` is low for 2 cycles, `collision_cnt` = 2, and r7 ends as 0x33.
- **Parallel groups:** LSU and IXU1 on rd 9, IXU2 and BRANCH on rd 10 → cycle 1 writes LSU and IXU2; cycle 2 writes IXU1 and BRANCH.
- **Saturation:** force 70000 collision cycles → `collision_cnt` holds at 0xFFFF.
